// File: rtl/sprite_store_ctrl_if.sv
// Purpose: groups the OAM-candidate, render and fetcher signals of the sprite
//          store sequencer into one bundle.
// Ports:   master drives candidates, render control and fetch_ack and observes
//          the fetch request, stall and occupancy. slave is the sequencer side.
interface sprite_store_ctrl_if #(
   parameter int IDX_W  = 6,
   parameter int LINE_W = 4,
   parameter int X_W    = 8
);
   // line control and OAM scanner
   logic              scan_start;
   logic              cand_valid;
   logic [IDX_W-1:0]  cand_idx;
   logic [LINE_W-1:0] cand_line;
   logic [X_W-1:0]    cand_x;
   // pixel pipe
   logic              render_en;
   logic [X_W-1:0]    pix_x;
   logic              stall;
   // sprite fetcher
   logic              fetch_req;
   logic [IDX_W-1:0]  fetch_idx;
   logic [LINE_W-1:0] fetch_line;
   logic              fetch_ack;
   // occupancy
   logic [3:0]        count;
   logic              full;

   modport master (
      output scan_start, cand_valid, cand_idx, cand_line, cand_x,
      output render_en, pix_x, fetch_ack,
      input  stall, fetch_req, fetch_idx, fetch_line, count, full
   );

   modport slave (
      input  scan_start, cand_valid, cand_idx, cand_line, cand_x,
      input  render_en, pix_x, fetch_ack,
      output stall, fetch_req, fetch_idx, fetch_line, count, full
   );
endinterface

// File: rtl/sprite_store_ctrl.sv
// Purpose: sprite store sequencer; allocates OAM candidates into slots during SCAN, then matches pixel X and hands hits to the fetcher.
// Latency: a candidate is stored on the edge it is presented; fetch_req rises 1 cycle after a match; stall is combinational.
// Backpressure: one fetch outstanding; fetch_req holds until fetch_ack, stall holds the pixel pipe while any match is unserved.
// Ports:   i_clk  clock, rising edge
//          i_rst  asynchronous active-high reset
//          io_bus slave side of sprite_store_ctrl_if (candidates, render, fetch, stall, count/full)
module sprite_store_ctrl #(
   parameter int SLOTS  = 10,
   parameter int IDX_W  = 6,
   parameter int LINE_W = 4,
   parameter int X_W    = 8
) (
   input  logic               i_clk,
   input  logic               i_rst,
   sprite_store_ctrl_if.slave io_bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_RENDER = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [SLOTS-1:0]  r_valid;
   logic [IDX_W-1:0]  r_idx  [SLOTS];
   logic [LINE_W-1:0] r_line [SLOTS];
   logic [X_W-1:0]    r_x    [SLOTS];
   logic [3:0]        r_count;

   logic              r_fetch_req;
   logic [IDX_W-1:0]  r_fetch_idx;
   logic [LINE_W-1:0] r_fetch_line;
   logic [3:0]        r_gnt;

   logic              w_full;
   logic              w_render;
   logic [SLOTS-1:0]  w_match;
   logic              w_any_match;
   logic [3:0]        w_gnt;
   logic [IDX_W-1:0]  w_gnt_idx;
   logic [LINE_W-1:0] w_gnt_line;
   logic              w_wr_en;
   logic              w_ack;
   logic              w_grant_en;

   // -----------------------------------------------------------------
   // Match and lowest-slot priority select
   // -----------------------------------------------------------------
   always_comb begin
      w_full      = (r_count == 4'(SLOTS));
      w_render    = (r_state == ST_RENDER);
      w_match     = '0;
      w_gnt       = '0;
      w_gnt_idx   = '0;
      w_gnt_line  = '0;
      for (int i = 0; i < SLOTS; i++) begin
         w_match[i] = w_render && r_valid[i] && (r_x[i] == io_bus.pix_x);
      end
      // walk downwards so the lowest matching slot is the last one assigned
      for (int i = SLOTS - 1; i >= 0; i--) begin
         if (w_match[i]) begin
            w_gnt      = 4'(i);
            w_gnt_idx  = r_idx[i];
            w_gnt_line = r_line[i];
         end
      end
      w_any_match = |w_match;
      w_wr_en     = (r_state == ST_SCAN) && io_bus.cand_valid && !w_full;
      w_ack       = r_fetch_req && io_bus.fetch_ack;
      // a grant needs an empty request slot; since the ack edge still sees
      // r_fetch_req=1, there is always one idle cycle between fetches.
      // render_en low blocks new grants while an old fetch drains.
      w_grant_en  = w_render && io_bus.render_en && !r_fetch_req && w_any_match;
   end

   // -----------------------------------------------------------------
   // FSM
   // -----------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (io_bus.scan_start) begin
         w_state_nxt = ST_SCAN;
      end else begin
         case (r_state)
            ST_IDLE:   w_state_nxt = ST_IDLE;
            ST_SCAN:   if (io_bus.render_en)  w_state_nxt = ST_RENDER;
            ST_RENDER: if (!io_bus.render_en) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // -----------------------------------------------------------------
   // Slot store, occupancy and fetch request
   // -----------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_valid      <= '0;
         r_count      <= '0;
         r_fetch_req  <= 1'b0;
         r_fetch_idx  <= '0;
         r_fetch_line <= '0;
         r_gnt        <= '0;
         for (int i = 0; i < SLOTS; i++) begin
            r_idx[i]  <= '0;
            r_line[i] <= '0;
            r_x[i]    <= '0;
         end
      end else if (io_bus.scan_start) begin
         // new line wins over everything, including a pending ack
         r_valid     <= '0;
         r_count     <= '0;
         r_fetch_req <= 1'b0;
      end else begin
         if (w_wr_en) begin
            for (int i = 0; i < SLOTS; i++) begin
               if (r_count == 4'(i)) begin
                  r_idx[i]   <= io_bus.cand_idx;
                  r_line[i]  <= io_bus.cand_line;
                  r_x[i]     <= io_bus.cand_x;
                  r_valid[i] <= 1'b1;
               end
            end
            r_count <= r_count + 4'd1;
         end
         if (w_ack) begin
            for (int i = 0; i < SLOTS; i++) begin
               if (r_gnt == 4'(i)) begin
                  r_valid[i] <= 1'b0;
               end
            end
            r_fetch_req <= 1'b0;
         end else if (w_grant_en) begin
            r_fetch_req  <= 1'b1;
            r_fetch_idx  <= w_gnt_idx;
            r_fetch_line <= w_gnt_line;
            r_gnt        <= w_gnt;
         end
      end
   end

   assign io_bus.stall      = w_any_match;
   assign io_bus.fetch_req  = r_fetch_req;
   assign io_bus.fetch_idx  = r_fetch_idx;
   assign io_bus.fetch_line = r_fetch_line;
   assign io_bus.count      = r_count;
   assign io_bus.full       = w_full;

endmodule

// File: tb/tb_sprite_store_ctrl.sv
// Purpose: directed self-checking bench for sprite_store_ctrl.
// Ports:   none; drives the master side of sprite_store_ctrl_if.
module tb_sprite_store_ctrl;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   sprite_store_ctrl_if #(.IDX_W(6), .LINE_W(4), .X_W(8)) bus ();

   sprite_store_ctrl #(
      .SLOTS  (10),
      .IDX_W  (6),
      .LINE_W (4),
      .X_W    (8)
   ) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_scan_start();
      bus.scan_start = 1'b1;
      tick();
      bus.scan_start = 1'b0;
   endtask

   task automatic add_cand(input logic [5:0] idx, input logic [3:0] line, input logic [7:0] x);
      bus.cand_valid = 1'b1;
      bus.cand_idx   = idx;
      bus.cand_line  = line;
      bus.cand_x     = x;
      tick();
      bus.cand_valid = 1'b0;
   endtask

   task automatic do_ack();
      bus.fetch_ack = 1'b1;
      tick();
      bus.fetch_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst            = 1'b1;
      bus.scan_start = 1'b0;
      bus.cand_valid = 1'b0;
      bus.cand_idx   = '0;
      bus.cand_line  = '0;
      bus.cand_x     = '0;
      bus.render_en  = 1'b0;
      bus.pix_x      = 8'd255;
      bus.fetch_ack  = 1'b0;
      #12;
      checks++; if (bus.count !== 4'd0)      begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count); end
      checks++; if (bus.full !== 1'b0)       begin errors++; $display("FAIL reset_full got %b exp 0", bus.full); end
      checks++; if (bus.fetch_req !== 1'b0)  begin errors++; $display("FAIL reset_fetch_req got %b exp 0", bus.fetch_req); end
      checks++; if (bus.fetch_idx !== 6'd0)  begin errors++; $display("FAIL reset_fetch_idx got %0d exp 0", bus.fetch_idx); end
      checks++; if (bus.fetch_line !== 4'd0) begin errors++; $display("FAIL reset_fetch_line got %0d exp 0", bus.fetch_line); end
      checks++; if (bus.stall !== 1'b0)      begin errors++; $display("FAIL reset_stall got %b exp 0", bus.stall); end
      rst = 1'b0;
      // IDLE ignores candidates until scan_start
      add_cand(6'd1, 4'd1, 8'd1);
      checks++; if (bus.count !== 4'd0)      begin errors++; $display("FAIL idle_ignore_count got %0d exp 0", bus.count); end
   endtask

   // 12 candidates; only the first ten fit
   task automatic test_fill();
      logic [3:0] exp_cnt;
      do_scan_start();
      for (int i = 0; i < 12; i++) begin
         add_cand(6'(i), 4'(i), 8'(8 * i));
         exp_cnt = (i + 1 > 10) ? 4'd10 : 4'(i + 1);
         checks++; if (bus.count !== exp_cnt) begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, bus.count, exp_cnt); end
         checks++; if (bus.full !== (i >= 9)) begin errors++; $display("FAIL fill_full[%0d] got %b exp %b", i, bus.full, (i >= 9)); end
      end
      bus.render_en = 1'b1;
      tick();
      bus.pix_x = 8'd80;  // would have been idx 10, which was dropped
      #1;
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL fill_dropped_stall got %b exp 0", bus.stall); end
      bus.pix_x = 8'd72;  // slot 9, idx 9
      #1;
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL fill_slot9_stall got %b exp 1", bus.stall); end
      tick();
      checks++; if (bus.fetch_req !== 1'b1) begin errors++; $display("FAIL fill_slot9_req got %b exp 1", bus.fetch_req); end
      checks++; if (bus.fetch_idx !== 6'd9) begin errors++; $display("FAIL fill_slot9_idx got %0d exp 9", bus.fetch_idx); end
      checks++; if (bus.fetch_line !== 4'd9) begin errors++; $display("FAIL fill_slot9_line got %0d exp 9", bus.fetch_line); end
      do_ack();
      checks++; if (bus.fetch_req !== 1'b0) begin errors++; $display("FAIL fill_ack_req got %b exp 0", bus.fetch_req); end
      checks++; if (bus.stall !== 1'b0)     begin errors++; $display("FAIL fill_ack_stall got %b exp 0", bus.stall); end
      checks++; if (bus.count !== 4'd10)    begin errors++; $display("FAIL fill_render_count got %0d exp 10", bus.count); end
      bus.pix_x = 8'd0;  // slot 0, idx 0
      tick();
      checks++; if (bus.fetch_idx !== 6'd0 || bus.fetch_req !== 1'b1) begin errors++; $display("FAIL fill_slot0 got req %b idx %0d exp req 1 idx 0", bus.fetch_req, bus.fetch_idx); end
      do_ack();
      bus.render_en = 1'b0;
      bus.pix_x     = 8'd255;
      tick();
   endtask

   // two slots at the same X: lowest first, one idle cycle between fetches
   task automatic test_two_match();
      do_scan_start();
      add_cand(6'd3, 4'd1, 8'd20);
      add_cand(6'd5, 4'd2, 8'd30);
      add_cand(6'd7, 4'd4, 8'd20);
      bus.render_en = 1'b1;
      tick();
      bus.pix_x = 8'd20;
      #1;
      checks++; if (bus.stall !== 1'b1)     begin errors++; $display("FAIL two_stall0 got %b exp 1", bus.stall); end
      checks++; if (bus.fetch_req !== 1'b0) begin errors++; $display("FAIL two_req0 got %b exp 0", bus.fetch_req); end
      tick();
      checks++; if (bus.fetch_req !== 1'b1 || bus.fetch_idx !== 6'd3 || bus.fetch_line !== 4'd1) begin errors++; $display("FAIL two_first got req %b idx %0d line %0d exp 1/3/1", bus.fetch_req, bus.fetch_idx, bus.fetch_line); end
      tick();
      checks++; if (bus.fetch_req !== 1'b1 || bus.fetch_idx !== 6'd3) begin errors++; $display("FAIL two_hold got req %b idx %0d exp 1/3", bus.fetch_req, bus.fetch_idx); end
      do_ack();
      checks++; if (bus.fetch_req !== 1'b0) begin errors++; $display("FAIL two_idle_req got %b exp 0", bus.fetch_req); end
      checks++; if (bus.stall !== 1'b1)     begin errors++; $display("FAIL two_idle_stall got %b exp 1", bus.stall); end
      tick();
      checks++; if (bus.fetch_req !== 1'b1 || bus.fetch_idx !== 6'd7 || bus.fetch_line !== 4'd4) begin errors++; $display("FAIL two_second got req %b idx %0d line %0d exp 1/7/4", bus.fetch_req, bus.fetch_idx, bus.fetch_line); end
      do_ack();
      checks++; if (bus.fetch_req !== 1'b0) begin errors++; $display("FAIL two_done_req got %b exp 0", bus.fetch_req); end
      checks++; if (bus.stall !== 1'b0)     begin errors++; $display("FAIL two_done_stall got %b exp 0", bus.stall); end
      tick();
      checks++; if (bus.fetch_req !== 1'b0) begin errors++; $display("FAIL two_no_regrant got %b exp 0", bus.fetch_req); end
      bus.render_en = 1'b0;
      bus.pix_x     = 8'd255;
      tick();
   endtask

   // X=0 hit in the first render cycle
   task automatic test_first_cycle();
      do_scan_start();
      add_cand(6'd12, 4'd5, 8'd0);
      bus.pix_x     = 8'd0;
      bus.render_en = 1'b1;
      tick();
      checks++; if (bus.stall !== 1'b1)     begin errors++; $display("FAIL first_stall got %b exp 1", bus.stall); end
      checks++; if (bus.fetch_req !== 1'b0) begin errors++; $display("FAIL first_req0 got %b exp 0", bus.fetch_req); end
      tick();
      checks++; if (bus.fetch_req !== 1'b1 || bus.fetch_idx !== 6'd12 || bus.fetch_line !== 4'd5) begin errors++; $display("FAIL first_grant got req %b idx %0d line %0d exp 1/12/5", bus.fetch_req, bus.fetch_idx, bus.fetch_line); end
      tick();
      checks++; if (bus.stall !== 1'b1)     begin errors++; $display("FAIL first_stall_hold got %b exp 1", bus.stall); end
      do_ack();
      checks++; if (bus.stall !== 1'b0)     begin errors++; $display("FAIL first_stall_end got %b exp 0", bus.stall); end
      bus.render_en = 1'b0;
      bus.pix_x     = 8'd255;
      tick();
   endtask

   // render_en falls mid-fetch: fetch finishes, nothing new granted
   task automatic test_render_end();
      do_scan_start();
      add_cand(6'd1, 4'd2, 8'd60);
      add_cand(6'd2, 4'd3, 8'd60);
      bus.render_en = 1'b1;
      tick();
      bus.pix_x = 8'd60;
      tick();
      checks++; if (bus.fetch_req !== 1'b1 || bus.fetch_idx !== 6'd1) begin errors++; $display("FAIL rend_grant got req %b idx %0d exp 1/1", bus.fetch_req, bus.fetch_idx); end
      bus.render_en = 1'b0;
      tick();
      checks++; if (bus.fetch_req !== 1'b1) begin errors++; $display("FAIL rend_drain got %b exp 1", bus.fetch_req); end
      do_ack();
      checks++; if (bus.fetch_req !== 1'b0) begin errors++; $display("FAIL rend_ack got %b exp 0", bus.fetch_req); end
      tick();
      checks++; if (bus.fetch_req !== 1'b0) begin errors++; $display("FAIL rend_no_grant got %b exp 0", bus.fetch_req); end
      checks++; if (bus.count !== 4'd2)     begin errors++; $display("FAIL rend_count got %0d exp 2", bus.count); end
      bus.pix_x = 8'd255;
   endtask

   // scan_start while a fetch is pending
   task automatic test_scan_abort();
      do_scan_start();
      add_cand(6'd9, 4'd3, 8'd40);
      add_cand(6'd10, 4'd6, 8'd41);
      bus.render_en = 1'b1;
      tick();
      bus.pix_x = 8'd40;
      tick();
      checks++; if (bus.fetch_req !== 1'b1) begin errors++; $display("FAIL abort_pre_req got %b exp 1", bus.fetch_req); end
      bus.render_en  = 1'b0;
      bus.scan_start = 1'b1;
      tick();
      bus.scan_start = 1'b0;
      checks++; if (bus.fetch_req !== 1'b0) begin errors++; $display("FAIL abort_req got %b exp 0", bus.fetch_req); end
      checks++; if (bus.count !== 4'd0)     begin errors++; $display("FAIL abort_count got %0d exp 0", bus.count); end
      do_ack();  // late ack
      checks++; if (bus.fetch_req !== 1'b0) begin errors++; $display("FAIL abort_late_ack got %b exp 0", bus.fetch_req); end
      bus.render_en = 1'b1;
      tick();
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL abort_valid40 got stall %b exp 0", bus.stall); end
      bus.pix_x = 8'd41;
      #1;
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL abort_valid41 got stall %b exp 0", bus.stall); end
      tick();
      checks++; if (bus.fetch_req !== 1'b0) begin errors++; $display("FAIL abort_no_grant got %b exp 0", bus.fetch_req); end
      bus.render_en = 1'b0;
      bus.pix_x     = 8'd255;
      tick();
   endtask

   // asynchronous reset in the middle of SCAN
   task automatic test_reset_mid_scan();
      do_scan_start();
      for (int i = 0; i < 4; i++) add_cand(6'(20 + i), 4'(i), 8'(100 + i));
      checks++; if (bus.count !== 4'd4) begin errors++; $display("FAIL rmid_pre_count got %0d exp 4", bus.count); end
      #3;
      rst = 1'b1;
      #1;
      checks++; if (bus.count !== 4'd0)     begin errors++; $display("FAIL rmid_count got %0d exp 0", bus.count); end
      checks++; if (bus.full !== 1'b0)      begin errors++; $display("FAIL rmid_full got %b exp 0", bus.full); end
      checks++; if (bus.fetch_req !== 1'b0) begin errors++; $display("FAIL rmid_req got %b exp 0", bus.fetch_req); end
      #1;
      rst = 1'b0;
      add_cand(6'd30, 4'd1, 8'd5);  // IDLE: must be ignored
      checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL rmid_idle_count got %0d exp 0", bus.count); end
   endtask

   // near miss: slot at 51, pixel at 50
   task automatic test_near_miss();
      do_scan_start();
      add_cand(6'd20, 4'd6, 8'd51);
      bus.render_en = 1'b1;
      tick();
      bus.pix_x = 8'd50;
      #1;
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL miss_stall got %b exp 0", bus.stall); end
      tick();
      tick();
      checks++; if (bus.fetch_req !== 1'b0) begin errors++; $display("FAIL miss_req got %b exp 0", bus.fetch_req); end
      bus.pix_x = 8'd51;
      #1;
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL hit51_stall got %b exp 1", bus.stall); end
      tick();
      checks++; if (bus.fetch_req !== 1'b1 || bus.fetch_idx !== 6'd20 || bus.fetch_line !== 4'd6) begin errors++; $display("FAIL hit51_grant got req %b idx %0d line %0d exp 1/20/6", bus.fetch_req, bus.fetch_idx, bus.fetch_line); end
      do_ack();
      bus.render_en = 1'b0;
      bus.pix_x     = 8'd255;
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_fill();
      test_two_match();
      test_first_cycle();
      test_render_end();
      test_scan_abort();
      test_reset_mid_scan();
      test_near_miss();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
